// File: rtl/cond_pkg.sv
// Shared constants for the conditional-execution stage: ARM condition codes
// and NZCV flag bit positions.
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/condcheck.sv
// Purely combinational condition evaluator: Cond + {N,Z,C,V} -> CondEx.
module condcheck
    import cond_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v;

    always_comb begin
        n = Flags[FLAG_N];
        z = Flags[FLAG_Z];
        c = Flags[FLAG_C];
        v = Flags[FLAG_V];
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = ~z & (n == v);
            COND_LE: CondEx = z | (n != v);
            COND_AL: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/condlogic.sv
// Conditional-execution stage: NZCV register, latched condition result and
// write-enable gating. Optional saturating statistics under COND_STATS_EN.
module condlogic
    import cond_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       CondLatch,
    input  logic       PCS,
    input  logic       NextPC,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       IsLongMul,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       WriteHi,
    output logic [3:0] Flags,
    output logic       CondExR
`ifdef COND_STATS_EN
    ,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SkipCount
`endif
);

    logic [3:0] flags_q, flags_d;
    logic       cexr_q, cexr_d;
    logic       cond_ex;
    logic [1:0] flag_write;

    // Evaluated against the registered flags, so a same-cycle flag write
    // does not affect the condition being latched.
    condcheck u_condcheck (
        .Cond   (Cond),
        .Flags  (flags_q),
        .CondEx (cond_ex)
    );

    always_comb begin
        flag_write = FlagW & {2{cexr_q}};
        flags_d    = flags_q;
        if (flag_write[1]) begin
            flags_d[FLAG_N] = ALUFlags[FLAG_N];
            flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
        end
        if (flag_write[0]) begin
            flags_d[FLAG_C] = ALUFlags[FLAG_C];
            flags_d[FLAG_V] = ALUFlags[FLAG_V];
        end
        cexr_d = CondLatch ? cond_ex : cexr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= '0;
            cexr_q  <= 1'b0;
        end else begin
            flags_q <= flags_d;
            cexr_q  <= cexr_d;
        end
    end

    assign PCWrite  = NextPC | (PCS & cexr_q);
    assign RegWrite = RegW & cexr_q;
    assign MemWrite = MemW & cexr_q;
    assign WriteHi  = RegWrite & IsLongMul;
    assign Flags    = flags_q;
    assign CondExR  = cexr_q;

`ifdef COND_STATS_EN
    logic [CNT_W-1:0] exec_q, exec_d;
    logic [CNT_W-1:0] skip_q, skip_d;

    always_comb begin
        exec_d = exec_q;
        skip_d = skip_q;
        if (CondLatch) begin
            if (cond_ex) begin
                if (exec_q != '1) exec_d = exec_q + 1'b1;
            end else begin
                if (skip_q != '1) skip_d = skip_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exec_q <= '0;
            skip_q <= '0;
        end else begin
            exec_q <= exec_d;
            skip_q <= skip_d;
        end
    end

    assign ExecCount = exec_q;
    assign SkipCount = skip_q;
`else
    if (CNT_W < 1) begin : g_cnt_w_invalid
        $error("condlogic: CNT_W must be at least 1");
    end
`endif

endmodule

// File: tb/tb_condlogic.sv
// Self-checking bench for condlogic: directed vector table, reset and counter
// sequences, then randomized stimulus against a behavioural reference model.
module tb_condlogic;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond, ALUFlags;
    logic [1:0] FlagW;
    logic       CondLatch, PCS, NextPC, RegW, MemW, IsLongMul;
    logic       PCWrite, RegWrite, MemWrite, WriteHi, CondExR;
    logic [3:0] Flags;
`ifdef COND_STATS_EN
    logic [15:0] ExecCount, SkipCount;
    logic [3:0]  ExecSat, SkipSat;
`endif

    always #5 clk = ~clk;

    condlogic #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .CondLatch(CondLatch), .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
        .IsLongMul(IsLongMul), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .WriteHi(WriteHi), .Flags(Flags), .CondExR(CondExR)
`ifdef COND_STATS_EN
        , .ExecCount(ExecCount), .SkipCount(SkipCount)
`endif
    );

`ifdef COND_STATS_EN
    condlogic #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .CondLatch(CondLatch), .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
        .IsLongMul(IsLongMul), .PCWrite(), .RegWrite(), .MemWrite(), .WriteHi(),
        .Flags(), .CondExR(), .ExecCount(ExecSat), .SkipCount(SkipSat)
    );
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model state
    logic [3:0] m_flags;
    logic       m_cexr;
    int unsigned m_exec, m_skip;

    typedef struct {
        logic [3:0] cond, alu;
        logic [1:0] fw;
        logic lat, pcs, npc, rw, mw, lm;
        logic e_pcw, e_rw, e_mw, e_hi;
        logic [3:0] e_flags;
        logic e_cexr;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pairs of codes share a base test; odd codes invert it, 1111 never runs.
    function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = (n == v) && !z;
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !base : base;
    endfunction

    function automatic vec_t mk(input logic [3:0] cond, input logic [3:0] alu,
                                input logic [1:0] fw, input logic lat, input logic pcs,
                                input logic npc, input logic rw, input logic mw,
                                input logic lm, input logic e_pcw, input logic e_rw,
                                input logic e_mw, input logic e_hi,
                                input logic [3:0] e_flags, input logic e_cexr);
        vec_t r;
        r.cond = cond; r.alu = alu; r.fw = fw; r.lat = lat; r.pcs = pcs; r.npc = npc;
        r.rw = rw; r.mw = mw; r.lm = lm; r.e_pcw = e_pcw; r.e_rw = e_rw;
        r.e_mw = e_mw; r.e_hi = e_hi; r.e_flags = e_flags; r.e_cexr = e_cexr;
        return r;
    endfunction

    task automatic clear_inputs();
        Cond = 4'h0; ALUFlags = 4'h0; FlagW = 2'b00; CondLatch = 1'b0;
        PCS = 1'b0; NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0; IsLongMul = 1'b0;
    endtask

    task automatic model_reset();
        m_flags = 4'h0; m_cexr = 1'b0; m_exec = 0; m_skip = 0;
    endtask

    // Advance one clock: inputs are already applied; the model follows the edge.
    task automatic tick();
        logic ce;
        @(posedge clk);
        if (!reset) begin
            ce = cond_ref(Cond, m_flags);
            if (FlagW[1] && m_cexr) m_flags[3:2] = ALUFlags[3:2];
            if (FlagW[0] && m_cexr) m_flags[1:0] = ALUFlags[1:0];
            if (CondLatch) begin
                m_cexr = ce;
                if (ce) m_exec++; else m_skip++;
            end
        end
        #1;
    endtask

    task automatic check_model();
        @(negedge clk);
        chk("rnd_pcwrite",  PCWrite,  NextPC | (PCS & m_cexr));
        chk("rnd_regwrite", RegWrite, RegW & m_cexr);
        chk("rnd_memwrite", MemWrite, MemW & m_cexr);
        chk("rnd_writehi",  WriteHi,  RegW & m_cexr & IsLongMul);
        chk("rnd_flags",    Flags,    m_flags);
        chk("rnd_condexr",  CondExR,  m_cexr);
`ifdef COND_STATS_EN
        chk("rnd_exec", ExecCount, (m_exec > 65535) ? 65535 : m_exec);
        chk("rnd_skip", SkipCount, (m_skip > 65535) ? 65535 : m_skip);
        chk("rnd_exec_sat", ExecSat, (m_exec > 15) ? 15 : m_exec);
        chk("rnd_skip_sat", SkipSat, (m_skip > 15) ? 15 : m_skip);
`endif
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        model_reset();

        //        cond  alu   fw    lat pcs npc rw mw lm | pcw rw mw hi flags cexr
        tbl.push_back(mk(4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0));
        tbl.push_back(mk(4'h0, 4'h0, 2'b00, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 4'h0, 0));
        tbl.push_back(mk(4'hE, 4'h0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0));
        tbl.push_back(mk(4'h0, 4'h0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 4'h0, 1));
        tbl.push_back(mk(4'h0, 4'h4, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 1));
        tbl.push_back(mk(4'h0, 4'h0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h4, 1));
        tbl.push_back(mk(4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h4, 1));
        tbl.push_back(mk(4'h1, 4'h0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h4, 1));
        tbl.push_back(mk(4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4'h4, 0));
        tbl.push_back(mk(4'h0, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h4, 0));
        tbl.push_back(mk(4'hE, 4'h0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h4, 0));
        tbl.push_back(mk(4'h0, 4'h0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h4, 1));
        tbl.push_back(mk(4'h4, 4'h8, 2'b11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 1));
        tbl.push_back(mk(4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h8, 0));
        tbl.push_back(mk(4'hE, 4'h0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h8, 0));
        tbl.push_back(mk(4'h0, 4'hF, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h8, 1));
        tbl.push_back(mk(4'h0, 4'h0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 1));
        tbl.push_back(mk(4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hC, 1));
        tbl.push_back(mk(4'h0, 4'h0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 4'hC, 1));
        tbl.push_back(mk(4'h0, 4'h0, 2'b00, 0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 4'hC, 1));
        tbl.push_back(mk(4'hF, 4'h0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hC, 1));
        tbl.push_back(mk(4'h0, 4'h0, 2'b11, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 4'hC, 0));
        tbl.push_back(mk(4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hC, 0));
        tbl.push_back(mk(4'h0, 4'h0, 2'b00, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 4'hC, 0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_flags", Flags, 4'h0);
        chk("reset_condexr", CondExR, 1'b0);
`ifdef COND_STATS_EN
        chk("reset_exec", ExecCount, 16'd0);
        chk("reset_skip", SkipCount, 16'd0);
`endif
        reset = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            Cond = tbl[i].cond; ALUFlags = tbl[i].alu; FlagW = tbl[i].fw;
            CondLatch = tbl[i].lat; PCS = tbl[i].pcs; NextPC = tbl[i].npc;
            RegW = tbl[i].rw; MemW = tbl[i].mw; IsLongMul = tbl[i].lm;
            @(negedge clk);
            chk($sformatf("vec%0d_pcwrite", i),  PCWrite,  tbl[i].e_pcw);
            chk($sformatf("vec%0d_regwrite", i), RegWrite, tbl[i].e_rw);
            chk($sformatf("vec%0d_memwrite", i), MemWrite, tbl[i].e_mw);
            chk($sformatf("vec%0d_writehi", i),  WriteHi,  tbl[i].e_hi);
            chk($sformatf("vec%0d_flags", i),    Flags,    tbl[i].e_flags);
            chk($sformatf("vec%0d_condexr", i),  CondExR,  tbl[i].e_cexr);
            tick();
        end

        // Reset mid-instruction must suppress pending writes at once.
        clear_inputs();
        Cond = 4'hE; CondLatch = 1'b1;
        tick();
        clear_inputs();
        RegW = 1'b1; MemW = 1'b1; PCS = 1'b1;
        @(negedge clk);
        chk("pre_reset_regwrite", RegWrite, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_regwrite", RegWrite, 1'b0);
        chk("async_reset_memwrite", MemWrite, 1'b0);
        chk("async_reset_pcwrite",  PCWrite,  1'b0);
        chk("async_reset_condexr",  CondExR,  1'b0);
        model_reset();
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

`ifdef COND_STATS_EN
        for (int k = 0; k < 5; k++) begin
            clear_inputs();
            Cond = (k < 3) ? 4'hE : 4'hF;
            CondLatch = 1'b1;
            tick();
        end
        clear_inputs();
        @(negedge clk);
        chk("stats_exec3", ExecCount, 16'd3);
        chk("stats_skip2", SkipCount, 16'd2);
        for (int k = 0; k < 20; k++) begin
            Cond = 4'hE; CondLatch = 1'b1;
            tick();
        end
        clear_inputs();
        @(negedge clk);
        chk("stats_sat_exec", ExecSat, 4'd15);
        chk("stats_exec23", ExecCount, 16'd23);
        @(posedge clk); #1;
`endif

        for (int k = 0; k < 400; k++) begin
            Cond      = 4'($urandom_range(0, 15));
            ALUFlags  = 4'($urandom_range(0, 15));
            FlagW     = 2'($urandom_range(0, 3));
            CondLatch = ($urandom_range(0, 3) == 0);
            PCS       = 1'($urandom_range(0, 1));
            NextPC    = ($urandom_range(0, 3) == 0);
            RegW      = 1'($urandom_range(0, 1));
            MemW      = 1'($urandom_range(0, 1));
            IsLongMul = 1'($urandom_range(0, 1));
            check_model();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
